// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end for the pipelined MIPS core.
// Keeps its own fetch PC and issues in-order requests to an instruction
// memory of any latency of one cycle or more. It buffers the returned
// instructions with their PCs in a DEPTH-entry FIFO and presents the head
// to IF/ID through a valid/ready handshake. A redirect flushes the FIFO and
// marks the responses still in flight to be discarded.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   redirect, redirect_pc PC redirect (branch/jr/jump) and its target
//   halt                  stop issuing new requests; the FIFO still drains
//   imem_req, imem_addr   request valid and address (the current fetch PC)
//   imem_gnt              memory accepts the request this cycle
//   imem_rvalid/rdata     in-order response
//   instr_valid, instr,   FIFO head valid, head instruction and head PC
//   instr_pc
//   instr_ready           IF/ID accepts the head
//   count                 FIFO occupancy (debug)
module fetch_queue #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_OUT  = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       redirect,
  input  logic [ADDR_W-1:0]          redirect_pc,
  input  logic                       halt,
  output logic                       imem_req,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic                       imem_gnt,
  input  logic                       imem_rvalid,
  input  logic [DATA_W-1:0]          imem_rdata,
  output logic                       instr_valid,
  output logic [DATA_W-1:0]          instr,
  output logic [ADDR_W-1:0]          instr_pc,
  input  logic                       instr_ready,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned IF_W  = $clog2(MAX_OUT + 1);
  localparam int unsigned TAG_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  logic [ADDR_W-1:0] fetch_pc;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [IF_W-1:0]   inflight;
  logic [IF_W-1:0]   drop;
  logic [TAG_W-1:0]  tag_rd;
  logic [TAG_W-1:0]  tag_wr;

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [ADDR_W-1:0] tag_mem  [MAX_OUT];

  logic              issue;
  logic              rsp;
  logic              rsp_keep;
  logic              rsp_drop;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] rsp_pc;
  logic [PTR_W-1:0]  rd_ptr_inc;
  logic [TAG_W-1:0]  tag_rd_inc;
  logic [TAG_W-1:0]  tag_wr_inc;

  // Issue only when a FIFO slot is guaranteed for every outstanding response.
  assign imem_req = !reset && !halt && !redirect &&
                    (inflight < IF_W'(MAX_OUT)) &&
                    ((32'(count) + 32'(inflight)) < 32'(DEPTH));
  assign imem_addr   = fetch_pc;
  assign instr_valid = (count != '0);

  assign issue    = imem_req && imem_gnt;
  // A response with nothing outstanding (e.g. one abandoned by reset) is ignored.
  assign rsp      = imem_rvalid && (inflight != '0);
  assign rsp_drop = rsp && (drop != '0);
  assign rsp_keep = rsp && (drop == '0);
  assign push     = rsp_keep && !redirect;
  assign pop      = instr_valid && instr_ready && !redirect;
  assign rsp_pc   = tag_mem[tag_rd];

  assign rd_ptr_inc = rd_ptr + PTR_W'(1);
  assign tag_rd_inc = (tag_rd == TAG_W'(MAX_OUT - 1)) ? '0 : tag_rd + TAG_W'(1);
  assign tag_wr_inc = (tag_wr == TAG_W'(MAX_OUT - 1)) ? '0 : tag_wr + TAG_W'(1);

  // Storage arrays carry no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]   <= rsp_pc;
    end
    if (issue) begin
      tag_mem[tag_wr] <= fetch_pc;
    end
  end

  // Control state and registered head outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= '0;
      drop     <= '0;
      tag_rd   <= '0;
      tag_wr   <= '0;
      instr    <= '0;
      instr_pc <= '0;
    end else if (redirect) begin
      // Everything still outstanding after this edge is stale. Dropped
      // responses never had their tags kept, so the tag FIFO restarts empty.
      fetch_pc <= redirect_pc;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      tag_rd   <= '0;
      tag_wr   <= '0;
      inflight <= inflight - IF_W'(rsp);
      drop     <= inflight - IF_W'(rsp);
    end else begin
      if (issue) begin
        fetch_pc <= fetch_pc + ADDR_W'(4);
        tag_wr   <= tag_wr_inc;
      end
      if (rsp_keep) begin
        tag_rd <= tag_rd_inc;
      end
      if (rsp_drop) begin
        drop <= drop - IF_W'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr_inc;
      end
      count    <= count + CNT_W'(push) - CNT_W'(pop);
      inflight <= inflight + IF_W'(issue) - IF_W'(rsp);
      // Head register follows the entry that will be at rd_ptr next cycle.
      if (pop && (count > CNT_W'(1))) begin
        instr    <= data_mem[rd_ptr_inc];
        instr_pc <= pc_mem[rd_ptr_inc];
      end else if (push && ((count == '0) || (pop && (count == CNT_W'(1))))) begin
        instr    <= imem_rdata;
        instr_pc <= rsp_pc;
      end
    end
  end

endmodule
